// File: rtl/ex_mem.sv
// EX/MEM pipeline register: carries the EX write-back and HI/LO results into MEM,
// and returns the multi-cycle accumulator state (hilo_temp/cnt) to EX.
// Latency: one clk from ex_* to mem_*. No combinational input-to-output path.
// Backpressure: stall_mem holds every output; stall_ex alone inserts a bubble.
//
// Ports:
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   stall_ex, stall_mem       stage stall requests (stall_mem dominates)
//   flush                     kill stage contents (zeroes all outputs)
//   ex_wd/ex_wreg/ex_wdata    EX write-back address / enable / result
//   ex_whilo/ex_hi/ex_lo      EX HI/LO write request and values
//   hilo_temp_i/cnt_i         partial accumulator and cycle index from EX
//   mem_*                     registered copies to MEM (and HI/LO bypass)
//   hilo_temp_o/cnt_o         accumulator state returned to EX
//   bubble_cnt_o              bubble-cycle counter, only with EX_MEM_BUBBLE_CNT_EN
//
// Optional feature: define EX_MEM_BUBBLE_CNT_EN to add bubble_cnt_o.

module ex_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_ex,
  input  logic        stall_mem,
  input  logic        flush,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic        ex_whilo,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [63:0] hilo_temp_i,
  input  logic [1:0]  cnt_i,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic        mem_whilo,
  output logic [31:0] mem_hi,
  output logic [31:0] mem_lo,
`ifdef EX_MEM_BUBBLE_CNT_EN
  output logic [31:0] bubble_cnt_o,
`endif
  output logic [63:0] hilo_temp_o,
  output logic [1:0]  cnt_o
);

  logic [4:0]  wd_q,    wd_d;
  logic        wreg_q,  wreg_d;
  logic [31:0] wdata_q, wdata_d;
  logic        whilo_q, whilo_d;
  logic [31:0] hi_q,    hi_d;
  logic [31:0] lo_q,    lo_d;
  logic [63:0] hilo_temp_q, hilo_temp_d;
  logic [1:0]  cnt_q,   cnt_d;

`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
`endif

  // Priority: rst > flush > hold > bubble > advance.
  always_comb begin
    // Default is hold: every register keeps its value.
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    whilo_d     = whilo_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    hilo_temp_d = hilo_temp_q;
    cnt_d       = cnt_q;
`ifdef EX_MEM_BUBBLE_CNT_EN
    bubble_cnt_d = bubble_cnt_q;
`endif

    if (rst || flush) begin
      wd_d        = '0;
      wreg_d      = 1'b0;
      wdata_d     = '0;
      whilo_d     = 1'b0;
      hi_d        = '0;
      lo_d        = '0;
      hilo_temp_d = '0;
      cnt_d       = '0;
`ifdef EX_MEM_BUBBLE_CNT_EN
      // Counter survives flush; only reset clears it.
      if (rst) bubble_cnt_d = '0;
`endif
    end else if (stall_mem) begin
      // hold: defaults already applied
    end else if (stall_ex) begin
      // Bubble into MEM, but keep the multi-cycle op's progress for EX.
      wd_d        = '0;
      wreg_d      = 1'b0;
      wdata_d     = '0;
      whilo_d     = 1'b0;
      hi_d        = '0;
      lo_d        = '0;
      hilo_temp_d = hilo_temp_i;
      cnt_d       = cnt_i;
`ifdef EX_MEM_BUBBLE_CNT_EN
      bubble_cnt_d = bubble_cnt_q + 32'd1;  // wraps to 0 naturally
`endif
    end else begin
      // Advance: register 0 writes pass through untouched; the regfile drops them.
      wd_d        = ex_wd;
      wreg_d      = ex_wreg;
      wdata_d     = ex_wdata;
      whilo_d     = ex_whilo;
      hi_d        = ex_hi;
      lo_d        = ex_lo;
      hilo_temp_d = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    wd_q        <= wd_d;
    wreg_q      <= wreg_d;
    wdata_q     <= wdata_d;
    whilo_q     <= whilo_d;
    hi_q        <= hi_d;
    lo_q        <= lo_d;
    hilo_temp_q <= hilo_temp_d;
    cnt_q       <= cnt_d;
`ifdef EX_MEM_BUBBLE_CNT_EN
    bubble_cnt_q <= bubble_cnt_d;
`endif
  end

  assign mem_wd      = wd_q;
  assign mem_wreg    = wreg_q;
  assign mem_wdata   = wdata_q;
  assign mem_whilo   = whilo_q;
  assign mem_hi      = hi_q;
  assign mem_lo      = lo_q;
  assign hilo_temp_o = hilo_temp_q;
  assign cnt_o       = cnt_q;
`ifdef EX_MEM_BUBBLE_CNT_EN
  assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 SHALL have no parameters; widths are fixed: data 32, register address 5, accumulator 64, count 2.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port stall_ex  input  1  EX stage stalled this cycle.
REQ-005 SHALL have port stall_mem  input  1  MEM stage stalled this cycle.
REQ-006 SHALL have port flush  input  1  discard stage contents (exception/branch kill).
REQ-007 SHALL have ports ex_wd  input  5, ex_wreg  input  1, ex_wdata  input  32: EX write-back address, write enable and result.
REQ-008 SHALL have ports ex_whilo  input  1, ex_hi  input  32, ex_lo  input  32: EX HI/LO write request and values.
REQ-009 SHALL have ports hilo_temp_i  input  64, cnt_i  input  2: partial accumulator and cycle index of a multi-cycle EX op.
REQ-010 SHALL have ports mem_wd  output  5, mem_wreg  output  1, mem_wdata  output  32: registered copies to MEM.
REQ-011 SHALL have ports mem_whilo  output  1, mem_hi  output  32, mem_lo  output  32: registered HI/LO copies to MEM and to the EX bypass.
REQ-012 SHALL have ports hilo_temp_o  output  64, cnt_o  output  2: accumulator state returned to EX.

Function
REQ-013 SHALL update all outputs only on rising clk; no combinational input-to-output path.
REQ-014 SHALL apply priority per cycle: rst > flush > hold > bubble > advance.
REQ-015 Hold (stall_mem=1): every output keeps its value, including hilo_temp_o/cnt_o.
REQ-016 Bubble (stall_ex=1, stall_mem=0): mem_wd=0, mem_wreg=0, mem_wdata=0, mem_whilo=0, mem_hi=0, mem_lo=0; hilo_temp_o<=hilo_temp_i, cnt_o<=cnt_i.
REQ-017 Advance (stall_ex=0, stall_mem=0): all mem_* outputs capture their ex_* inputs unchanged; hilo_temp_o<=0, cnt_o<=0.
REQ-018 stall_ex=0 with stall_mem=1 SHALL be treated as hold (stall_mem dominates).
REQ-019 Flush: all outputs including hilo_temp_o and cnt_o <= 0 regardless of stall inputs.
REQ-020 Latency: one cycle from ex_* to mem_* when advancing; a held entry is never lost or duplicated.
REQ-021 SHALL pass ex_wd=0 with ex_wreg=1 unchanged; suppression of register 0 is the register file's job.
REQ-022 hilo_temp/cnt SHALL survive any number of consecutive bubble cycles, so EX resumes the multi-cycle op from cnt_o.

Reset
REQ-023 On rst=1 at a clk edge, every output SHALL become 0, overriding flush and stall.
REQ-024 rst asserted mid multi-cycle op SHALL clear cnt_o and hilo_temp_o; no partial result survives.

Configuration
REQ-025 With EX_MEM_BUBBLE_CNT_EN defined, SHALL add output bubble_cnt_o (32 bits) counting cycles in which the bubble case (REQ-016) was taken.
REQ-026 bubble_cnt_o SHALL wrap 0xFFFFFFFF->0, clear on rst only (not on flush), and hold during hold cycles.
REQ-027 Without EX_MEM_BUBBLE_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Advance: ex_wd=5, ex_wreg=1, ex_wdata=0x1234ABCD, no stall -> next cycle mem_wd=5, mem_wreg=1, mem_wdata=0x1234ABCD, cnt_o=0.
REQ-029 Bubble: stall_ex=1, stall_mem=0, cnt_i=1, hilo_temp_i=0x00000001_FFFFFFFE -> mem_wreg=0, mem_whilo=0, cnt_o=1, hilo_temp_o=0x00000001_FFFFFFFE; repeat 3 cycles, values unchanged.
REQ-030 Hold: load mem_wdata=0xDEADBEEF, then stall_mem=1 for 4 cycles while ex_wdata=0x11111111 -> mem_wdata stays 0xDEADBEEF; first cycle after release -> 0x11111111.
REQ-031 Flush vs stall: flush=1 with stall_mem=1, ex_whilo=1 -> all outputs 0 next cycle; rst=1 with flush=1 -> all 0.
REQ-032 HI/LO: ex_whilo=1, ex_hi=0xAAAA0000, ex_lo=0x0000BBBB, advance -> mem_whilo=1, mem_hi=0xAAAA0000, mem_lo=0x0000BBBB.
REQ-033 Counter (macro on): 2 bubble cycles, 1 hold, 1 flush -> bubble_cnt_o=2; preload near wrap: 0xFFFFFFFF + 1 bubble -> 0.
